// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first; 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through byte FIFO, with sticky framing/parity/overrun flags.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ  = 65_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int BUFFER_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  input  logic                         rd_en,
  input  logic                         clear_err,
  output logic [7:0]                   data_o,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(BUFFER_SIZE):0] count,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overrun_err
);
  localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(BUFFER_SIZE);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(BUFFER_SIZE);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic            rx_s1_q, rx_s2_q;
  logic            settle_q, armed_q, armed_d;
  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, set_frame;
  logic            pop, wr_ok, set_ovr;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
  logic [7:0]      mem_q [BUFFER_SIZE];
`ifdef UART_RX_PARITY_EN
  logic            par_ok_q, par_ok_d, set_par;
  logic            parity_err_q, parity_err_d;
`endif

  // A line held low across reset must go high once before a start bit is accepted;
  // armed only sets from a synchronizer sample taken after reset release.
  assign armed_d = armed_q | (settle_q & rx_s1_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d  = par_ok_q;
    set_par   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_ok_d = 1'b1;
`endif
        if (armed_q && !rx_s2_q) state_d = S_START;
      end
      S_START: if (cnt_q == CNT_HALF) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        shift_d   = {rx_s2_q, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        par_ok_d = ~(^shift_q ^ rx_s2_q);
        state_d  = S_STOP;
      end
`endif
      S_STOP: if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (rx_s2_q) begin
`ifdef UART_RX_PARITY_EN
          if (par_ok_q) push = 1'b1;
          else          set_par = 1'b1;
`else
          push = 1'b1;
`endif
          state_d = S_IDLE;
        end else begin
          set_frame = 1'b1;
          state_d   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a pop frees the slot a same-cycle push lands in, so full+pop accepts the byte.
  always_comb begin
    pop     = rd_en && (count_q != '0);
    wr_ok   = push && ((count_q != CNT_FULL) || pop);
    set_ovr = push && (count_q == CNT_FULL) && !pop;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    frame_err_d   = set_frame | (frame_err_q & ~clear_err);
    overrun_err_d = set_ovr   | (overrun_err_q & ~clear_err);
`ifdef UART_RX_PARITY_EN
    parity_err_d  = set_par   | (parity_err_q & ~clear_err);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      settle_q      <= 1'b0;
      armed_q       <= 1'b0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q      <= 1'b1;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q       <= rx;
      rx_s2_q       <= rx_s1_q;
      settle_q      <= 1'b1;
      armed_q       <= armed_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q      <= par_ok_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_FULL);
  assign count       = count_q;
  assign data_o      = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at 10 clocks/bit, 4-byte FIFO; frames are checked against a
// queue-based model of received bytes and sticky flags.
module tb_uart_rx_fifo;
  localparam int CF = 1_000_000, BR = 100_000, BS = 4, CPB = CF / BR;

  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rd_en = 1'b0, clear_err = 1'b0;
  logic [7:0] data_o;
  logic       empty, full, frame_err, parity_err, overrun_err;
  logic [2:0] count;

  int n_vec = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, fall_cyc = -1;
  logic prev_empty = 1'b1;
  logic [7:0] mq[$];
  bit m_fe = 0, m_pe = 0, m_ov = 0;

  uart_rx_fifo #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .clear_err(clear_err),
    .data_o(data_o), .empty(empty), .full(full), .count(count),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (prev_empty && !empty) fall_cyc <= cyc;
    prev_empty <= empty;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(mq.size() == BS));
    if (mq.size() > 0) chk({tag, ".data"}, 32'(data_o), 32'(mq[0]));
    chk({tag, ".ferr"}, 32'(frame_err),   32'(m_fe));
    chk({tag, ".perr"}, 32'(parity_err),  32'(m_pe));
    chk({tag, ".oerr"}, 32'(overrun_err), 32'(m_ov));
  endtask

  // Drives one frame; pop_at_push raises rd_en around the mid-stop-bit sample.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit bad_par,
                            input bit pop_at_push);
    logic [7:0] d;
    d = b;
    start_cyc = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    tick(CPB);
`endif
    rx = stop;
    for (int i = 1; i <= CPB; i++) begin
      tick(1);
      if (i == 7) rd_en = pop_at_push;
      if (i == 8) rd_en = 1'b0;
    end
    if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
    if (!stop) m_fe = 1;
`ifdef UART_RX_PARITY_EN
    else if (bad_par) m_pe = 1;
`endif
    else if (mq.size() < BS) mq.push_back(b);
    else m_ov = 1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic read_one(input string tag);
    if (mq.size() > 0) begin
      chk({tag, ".rd"}, 32'(data_o), 32'(mq[0]));
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      void'(mq.pop_front());
    end
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    m_fe = 0; m_pe = 0; m_ov = 0;
  endtask

  initial begin
    logic [7:0] pat [5];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C; pat[3] = 8'h81; pat[4] = 8'h55;

    tick(3);
    chk("reset.data", 32'(data_o), 32'h0);
    check_all("reset");
    rst_n = 1'b1;
    tick(5);

    // single byte and latency of empty deassertion
    send(8'hA5);
    chk("a5.lat", 32'((fall_cyc - start_cyc) >= 90 && (fall_cyc - start_cyc) <= 100), 32'd1);
    check_all("a5");
    read_one("a5");
    check_all("a5.drain");

    // fill past capacity without reads
    for (int i = 0; i < 5; i++) send(pat[i]);
    check_all("ovr");
    for (int i = 0; i < 4; i++) read_one("ovr");
    check_all("ovr.drain");
    pulse_clear();
    check_all("ovr.clr");

    // pop coinciding with push while full
    for (int i = 0; i < 4; i++) send(8'($urandom));
    check_all("fullpop.pre");
    send_frame(8'($urandom), 1'b1, 1'b0, 1'b1);
    check_all("fullpop");
    while (mq.size() > 0) read_one("fullpop");

    // short glitch must be rejected, receiver still usable afterwards
    rx = 1'b0; tick(3); rx = 1'b1; tick(30);
    check_all("glitch");
    send(8'h6E);
    check_all("glitch.after");
    read_one("glitch");

    // framing error with break, then recovery
    send_frame(8'h42, 1'b0, 1'b0, 1'b0);
    tick(50);
    rx = 1'b1;
    tick(20);
    send(8'h17);
    check_all("frame");
    pulse_clear();
    check_all("frame.clr");
    read_one("frame");

    // reset mid-frame flushes FIFO; low line after release is not a start bit
    send(8'h99);
    rx = 1'b0;
    tick(40);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    mq.delete(); m_fe = 0; m_pe = 0; m_ov = 0;
    tick(30);
    check_all("midrst");
    rx = 1'b1;
    tick(20);
    send(8'hC3);
    check_all("midrst.after");
    read_one("midrst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check_all("par.bad");
    send(8'h07);
    check_all("par.good");
    read_one("par");
    pulse_clear();
`endif

    // randomized traffic with interleaved reads
    for (int it = 0; it < 14; it++) begin
      send(8'($urandom));
      check_all("rnd");
      if ($urandom_range(0, 2) != 0) begin
        int nr;
        nr = $urandom_range(0, 2);
        for (int k = 0; k < nr; k++) read_one("rnd");
      end
      tick($urandom_range(0, 5));
    end
    check_all("rnd.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Serial UART receiver (8N1, LSB first) with a first-word-fall-through receive FIFO.
- Sits between the `rx` board pin and the SOC peripheral bus; it is the receiving end of the SOC UART link.
- Recovers bytes from the line, buffers them, and reports framing, parity and overrun errors through sticky flags.

## Interface
Parameters:
- `CLOCK_FREQ`, 65_000_000, system clock in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `BUFFER_SIZE`, 32, FIFO depth in bytes; must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `rd_en`  in  1  pop the head byte; ignored when `empty`.
- `clear_err`  in  1  one-cycle pulse; clears all sticky error flags.
- `data_o`  out  8  FIFO head byte, valid while `!empty`.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `BUFFER_SIZE` bytes.
- `count`  out  $clog2(BUFFER_SIZE)+1  bytes currently stored.
- `frame_err`  out  1  sticky; stop bit sampled low.
- `parity_err`  out  1  sticky; parity mismatch.
- `overrun_err`  out  1  sticky; byte arrived while the FIFO was full.

## Operation
- `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE`, truncating integer division (564 at the default parameters).
- The bit counter is wide enough for `CLKS_PER_BIT`.
- `rx` passes through a 2-FF synchronizer; both stages reset to 1. Only the synchronized value is used.
- FSM states: IDLE, START, DATA, PARITY (only with `UART_RX_PARITY_EN`), STOP, WAIT_IDLE.
  - IDLE: a synchronized low → START, counter cleared.
  - START: at count `CLKS_PER_BIT/2 - 1`, sample the line. Low → DATA. High → IDLE (glitch rejected, nothing pushed).
  - DATA: sample every `CLKS_PER_BIT` cycles into a shift register, LSB first. After bit 7 → PARITY if enabled, otherwise → STOP.
  - PARITY: sample one bit and compare against the even parity of the data bits → STOP.
  - STOP: sample one bit.
    - High with parity OK: push the byte to the FIFO → IDLE.
    - High with parity mismatch: set `parity_err`, discard the byte → IDLE.
    - Low: set `frame_err`, discard the byte → WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized line reads high → IDLE. This covers break conditions.
- Push while `full` and no pop in the same cycle: byte dropped, `overrun_err` set, FIFO contents unchanged.
- Push and pop in the same cycle:
  - `count` unchanged.
  - When `full`, the push is accepted.
  - When `empty`, the pop is ignored and the push proceeds.
- Read/write pointers wrap modulo `BUFFER_SIZE`. `full` and `empty` are derived from `count`.
- Sticky error flags: if `clear_err` and a set condition occur in the same cycle, set wins.

## Timing
- Reset values:
  - `data_o` = 0, `empty` = 1, `full` = 0, `count` = 0, all error flags 0.
  - FSM in IDLE, pointers at 0.
- Latency from `rx` pin falling edge to START entry: 3 cycles (2 synchronizer cycles + 1 detect).
- Stop bit sampled about mid-bit. The push registers on that cycle; `empty` deasserts and `data_o` is valid on the next cycle.
- `rd_en` pop: `data_o` presents the next byte and `count` decrements one cycle after the `rd_en` edge.
- Error flags assert in the cycle after the offending sample.
- Reset asserted mid-frame: the partial byte is lost and the FIFO is flushed. After release the FSM is in IDLE; a line still low is treated as a new start bit only after it reads high and falls again (WAIT_IDLE is not entered).

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: frame is 8E1. PARITY state is present, `parity_err` is driven.
  - Undefined: frame is 8N1. PARITY state is removed, `parity_err` is constant 0.

## Test plan
All scenarios use `CLOCK_FREQ` = 1_000_000, `BAUD_RATE` = 100_000 (10 clocks/bit), `BUFFER_SIZE` = 4.
- Send 0xA5 at 8N1 → `empty` falls about 95 cycles after the start edge; `data_o` = 0xA5; `rd_en` pulse → `empty` = 1, `count` = 0.
- Send 0x00, 0xFF, 0x3C, 0x81, then 0x55 with no reads → `full` = 1, `count` = 4, `overrun_err` = 1; reads return 0x00, 0xFF, 0x3C, 0x81 in order.
- 3-cycle low glitch on `rx` → no push, FSM back in IDLE, no error flag set.
- Send 0x42 with the stop bit low, line held low for 50 cycles, then 0x17 → `frame_err` = 1, only 0x17 in the FIFO; `clear_err` → `frame_err` = 0.
- With `full` = 1, assert `rd_en` in the same cycle as a stop-bit push → `count` stays 4, no overrun.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err` = 1, FIFO empty; send 0x07 with parity 1 → 0x07 stored.
